regex_job_sequencer: RTL and testbench
======================================

REGEX_JOB_SEQUENCER -- requirements
Module: regex_job_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1_000_000, is the watchdog limit in cycles while the core is in STATUS_RUNNING.
REQ-002 Clock and reset SHALL be one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-003 job_valid in 1, job_ready out 1: job header handshake.
REQ-004 job_code_words in 16: number of 40-bit code words that follow.
REQ-005 job_string_len in 16: string length in bytes, 5 bytes per word, byte 0 in bits [7:0].
REQ-006 in_valid in 1, in_ready out 1, in_data in REG_WIDTH: word stream, code words first, then string words.
REQ-007 address_register, data_in_register, start_cc_pointer_register, end_cc_pointer_register out REG_WIDTH: drive the matching AXI_top inputs.
REQ-008 cmd_register out REG_WIDTH: AXI_top command.
REQ-009 status_register, data_o_register in REG_WIDTH: from AXI_top.
REQ-010 res_valid out 1, res_ready in 1: result handshake.
REQ-011 res_accept out 1, res_error out 1, res_cycles out REG_WIDTH: result payload, held stable while res_valid=1.

Function
REQ-012 States SHALL be IDLE, W_ADDR, W_CMD, W_NOP, PTR, START, CHECK, WAIT, READ_CC, CAPTURE, RESULT, CLEAR.
REQ-013 IDLE: job_ready=1; a job handshake latches both lengths, clears word index W to 0, sets S=job_code_words*4, and goes to W_ADDR; job_string_len=0 goes directly to RESULT with res_error=1.
REQ-014 W_ADDR: in_ready=1; an in_valid handshake drives address_register<=W and data_in_register<=in_data and goes to W_CMD; without in_valid the block stays in W_ADDR with cmd=CMD_NOP.
REQ-015 W_CMD drives cmd=CMD_WRITE for exactly one cycle; W_NOP drives CMD_NOP, increments W, and returns to W_ADDR, so each word takes at least 3 cycles.
REQ-016 A word is a string word once W>=job_code_words; the remaining byte count decrements by 5 per string word, saturating at 0; reaching 0 goes to PTR.
REQ-017 PTR drives start_cc=S+CC_PTR_OFFSET and end_cc=S+job_string_len-1+CC_PTR_OFFSET, computed modulo 2^REG_WIDTH.
REQ-018 START holds CMD_START for 2 cycles; CHECK then samples status_register: STATUS_RUNNING goes to WAIT; any other value goes to RESULT with res_error=1.
REQ-019 WAIT drives CMD_NOP until status!=STATUS_RUNNING: STATUS_ACCEPTED sets res_accept=1, STATUS_REJECTED sets res_accept=0, both go to READ_CC; any other value sets res_error=1 and goes to RESULT.
REQ-020 READ_CC drives CMD_READ_ELAPSED_CLOCK for one cycle; CAPTURE latches data_o_register into res_cycles and drives CMD_NOP.
REQ-021 RESULT asserts res_valid until res_ready; the handshake goes to CLEAR.
REQ-022 CLEAR drives CMD_RESET for one cycle, then CMD_NOP, then returns to IDLE.
REQ-023 job_ready=0 and in_ready=0 in every state other than the one that accepts them.

Reset
REQ-024 rst SHALL force IDLE at any state, including mid-load or WAIT, with all outputs 0, cmd=CMD_NOP, and res_valid=0; no CMD_RESET is issued to AXI_top.

Configuration
REQ-025 With JOB_SEQ_TIMEOUT_EN defined, a counter cleared on entry to WAIT ends the wait after TIMEOUT_CYCLES cycles: res_error=1, res_cycles=TIMEOUT_CYCLES, then RESULT.
REQ-026 Without JOB_SEQ_TIMEOUT_EN, WAIT has no counter and no timeout.

Structure
REQ-027 AXI_package SHALL hold REG_WIDTH, the CMD_* and STATUS_* constants, CC_PTR_OFFSET=16, and job_seq_state_t.
REQ-028 The watchdog SHALL be the sub-module job_seq_watchdog, instantiated only under JOB_SEQ_TIMEOUT_EN.

Verification
REQ-029 A bench SHALL cover the following scenarios:
- Job code=3, len=7, 5 string words offered -> writes at addresses 0..4, and only 5 words are consumed.
- Same job -> start_cc=0x1C, end_cc=0x22.
- Status RUNNING for 50 cycles, then ACCEPTED with data_o=123 -> res_accept=1, res_cycles=123, CMD_RESET pulses once after res_ready.
- Status stays IDLE after START -> res_error=1, no READ_CC.
- rst asserted in WAIT -> next cycle IDLE, cmd=CMD_NOP.
- JOB_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, status held RUNNING -> res_error=1 after 100 cycles in WAIT.
- in_valid gaps of 4 cycles -> no spurious CMD_WRITE.

Source files
------------

// File: rtl/regex_job_sequencer_pkg.sv
// Shared constants, AXI_top command/status codes and sequencer state type.
// The optional WAIT watchdog is enabled with the JOB_SEQ_TIMEOUT_EN macro.
package AXI_package;

   localparam int REG_WIDTH = 40;

   localparam logic [REG_WIDTH-1:0] CMD_NOP                = 40'd0;
   localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 40'd1;
   localparam logic [REG_WIDTH-1:0] CMD_START              = 40'd2;
   localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 40'd3;
   localparam logic [REG_WIDTH-1:0] CMD_RESET              = 40'd4;

   localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = 40'd0;
   localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = 40'd1;
   localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = 40'd2;
   localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = 40'd3;

   localparam logic [REG_WIDTH-1:0] CC_PTR_OFFSET = 40'd16;

   typedef enum logic [3:0] {
      IDLE, W_ADDR, W_CMD, W_NOP, PTR, START, CHECK, WAIT,
      READ_CC, CAPTURE, RESULT, CLEAR
   } job_seq_state_t;

   // Each string word carries five bytes; the remaining count floors at zero.
   function automatic logic [15:0] bytesAfterWord(input logic [15:0] bytesLeft);
      return (bytesLeft > 16'd5) ? (bytesLeft - 16'd5) : 16'd0;
   endfunction

endpackage

// File: rtl/regex_job_sequencer_watchdog.sv
// WAIT-state watchdog: counts cycles while active, flags the final allowed cycle.
// Only instantiated when JOB_SEQ_TIMEOUT_EN is defined.
module job_seq_watchdog #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_active,
   output logic o_expired
);

   localparam logic [31:0] LAST_COUNT = 32'(TIMEOUT_CYCLES - 1);

   logic [31:0] r_count;

   assign o_expired = i_active && (r_count == LAST_COUNT);

   // Leaving WAIT clears the count, so every entry starts a fresh window.
   always_ff @(posedge i_clk) begin
      if (i_rst || !i_active) begin
         r_count <= 32'd0;
      end else if (!o_expired) begin
         r_count <= r_count + 32'd1;
      end
   end

endmodule

// File: rtl/regex_job_sequencer.sv
// Loads a regex job (code + string words) into AXI_top, runs it and returns the verdict.
// Define JOB_SEQ_TIMEOUT_EN to bound the WAIT state with job_seq_watchdog.
module regex_job_sequencer
   import AXI_package::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_job_valid,
   output logic                 o_job_ready,
   input  logic [15:0]          i_job_code_words,
   input  logic [15:0]          i_job_string_len,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic [REG_WIDTH-1:0] i_in_data,
   output logic [REG_WIDTH-1:0] o_address_register,
   output logic [REG_WIDTH-1:0] o_data_in_register,
   output logic [REG_WIDTH-1:0] o_start_cc_pointer_register,
   output logic [REG_WIDTH-1:0] o_end_cc_pointer_register,
   output logic [REG_WIDTH-1:0] o_cmd_register,
   input  logic [REG_WIDTH-1:0] i_status_register,
   input  logic [REG_WIDTH-1:0] i_data_o_register,
   output logic                 o_res_valid,
   input  logic                 i_res_ready,
   output logic                 o_res_accept,
   output logic                 o_res_error,
   output logic [REG_WIDTH-1:0] o_res_cycles
);

   localparam logic [REG_WIDTH-1:0] TIMEOUT_VALUE = REG_WIDTH'(TIMEOUT_CYCLES);

   job_seq_state_t       r_state;
   job_seq_state_t       w_nextState;
   logic [15:0]          r_codeWords;
   logic [15:0]          r_stringLen;
   logic [15:0]          r_bytesLeft;
   logic [16:0]          r_wordIdx;
   logic [17:0]          r_codeBase;
   logic                 r_phase;
   logic [REG_WIDTH-1:0] r_address;
   logic [REG_WIDTH-1:0] r_dataIn;
   logic [REG_WIDTH-1:0] r_startCc;
   logic [REG_WIDTH-1:0] r_endCc;
   logic                 r_resAccept;
   logic                 r_resError;
   logic [REG_WIDTH-1:0] r_resCycles;

   logic [REG_WIDTH-1:0] w_cmd;
   logic                 w_jobReady;
   logic                 w_inReady;
   logic                 w_resValid;
   logic                 w_isStringWord;
   logic [15:0]          w_bytesNext;
   logic                 w_timeout;
   logic                 w_statusDone;

   assign w_isStringWord = (r_wordIdx >= {1'b0, r_codeWords});
   assign w_bytesNext    = bytesAfterWord(r_bytesLeft);
   assign w_statusDone   = (i_status_register == STATUS_ACCEPTED) ||
                           (i_status_register == STATUS_REJECTED);

`ifdef JOB_SEQ_TIMEOUT_EN
   job_seq_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_active  (r_state == WAIT),
      .o_expired (w_timeout)
   );
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_cmd       = CMD_NOP;
      w_jobReady  = 1'b0;
      w_inReady   = 1'b0;
      w_resValid  = 1'b0;
      case (r_state)
         IDLE: begin
            w_jobReady = 1'b1;
            if (i_job_valid) begin
               w_nextState = (i_job_string_len == 16'd0) ? RESULT : W_ADDR;
            end
         end
         W_ADDR: begin
            w_inReady = 1'b1;
            if (i_in_valid) begin
               w_nextState = W_CMD;
            end
         end
         W_CMD: begin
            w_cmd       = CMD_WRITE;
            w_nextState = W_NOP;
         end
         W_NOP: begin
            w_nextState = (w_isStringWord && (w_bytesNext == 16'd0)) ? PTR : W_ADDR;
         end
         PTR: begin
            w_nextState = START;
         end
         START: begin
            w_cmd = CMD_START;
            if (r_phase) begin
               w_nextState = CHECK;
            end
         end
         CHECK: begin
            w_nextState = (i_status_register == STATUS_RUNNING) ? WAIT : RESULT;
         end
         WAIT: begin
            if (w_statusDone) begin
               w_nextState = READ_CC;
            end else if ((i_status_register != STATUS_RUNNING) || w_timeout) begin
               w_nextState = RESULT;
            end
         end
         READ_CC: begin
            w_cmd       = CMD_READ_ELAPSED_CLOCK;
            w_nextState = CAPTURE;
         end
         CAPTURE: begin
            w_nextState = RESULT;
         end
         RESULT: begin
            w_resValid = 1'b1;
            if (i_res_ready) begin
               w_nextState = CLEAR;
            end
         end
         CLEAR: begin
            if (!r_phase) begin
               w_cmd = CMD_RESET;
            end else begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Job bookkeeping and the registered AXI_top/result payload.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_codeWords <= 16'd0;
         r_stringLen <= 16'd0;
         r_bytesLeft <= 16'd0;
         r_wordIdx   <= 17'd0;
         r_codeBase  <= 18'd0;
         r_phase     <= 1'b0;
         r_address   <= '0;
         r_dataIn    <= '0;
         r_startCc   <= '0;
         r_endCc     <= '0;
         r_resAccept <= 1'b0;
         r_resError  <= 1'b0;
         r_resCycles <= '0;
      end else begin
         r_phase <= ((r_state == START) || (r_state == CLEAR)) ? ~r_phase : 1'b0;
         case (r_state)
            IDLE: begin
               if (i_job_valid) begin
                  r_codeWords <= i_job_code_words;
                  r_stringLen <= i_job_string_len;
                  r_bytesLeft <= i_job_string_len;
                  r_wordIdx   <= 17'd0;
                  r_codeBase  <= {i_job_code_words, 2'b00};
                  r_resAccept <= 1'b0;
                  r_resError  <= (i_job_string_len == 16'd0);
                  r_resCycles <= '0;
               end
            end
            W_ADDR: begin
               if (i_in_valid) begin
                  r_address <= REG_WIDTH'(r_wordIdx);
                  r_dataIn  <= i_in_data;
               end
            end
            W_NOP: begin
               r_wordIdx <= r_wordIdx + 17'd1;
               if (w_isStringWord) begin
                  r_bytesLeft <= w_bytesNext;
               end
            end
            PTR: begin
               r_startCc <= REG_WIDTH'(r_codeBase) + CC_PTR_OFFSET;
               r_endCc   <= REG_WIDTH'(r_codeBase) + REG_WIDTH'(r_stringLen)
                            - REG_WIDTH'(1) + CC_PTR_OFFSET;
            end
            CHECK: begin
               if (i_status_register != STATUS_RUNNING) begin
                  r_resError <= 1'b1;
               end
            end
            WAIT: begin
               if (i_status_register == STATUS_ACCEPTED) begin
                  r_resAccept <= 1'b1;
               end else if (i_status_register == STATUS_REJECTED) begin
                  r_resAccept <= 1'b0;
               end else if (i_status_register != STATUS_RUNNING) begin
                  r_resError <= 1'b1;
               end else if (w_timeout) begin
                  r_resError  <= 1'b1;
                  r_resCycles <= TIMEOUT_VALUE;
               end
            end
            CAPTURE: begin
               r_resCycles <= i_data_o_register;
            end
            default: begin
            end
         endcase
      end
   end

   // Handshakes and commands are masked while reset is held.
   assign o_job_ready                 = w_jobReady & ~i_rst;
   assign o_in_ready                  = w_inReady & ~i_rst;
   assign o_res_valid                 = w_resValid & ~i_rst;
   assign o_cmd_register              = i_rst ? CMD_NOP : w_cmd;
   assign o_address_register          = r_address;
   assign o_data_in_register          = r_dataIn;
   assign o_start_cc_pointer_register = r_startCc;
   assign o_end_cc_pointer_register   = r_endCc;
   assign o_res_accept                = r_resAccept;
   assign o_res_error                 = r_resError;
   assign o_res_cycles                = r_resCycles;

endmodule

// File: tb/tb_regex_job_sequencer.sv
// Self-checking bench for regex_job_sequencer with a transaction-level AXI_top model.
// Define JOB_SEQ_TIMEOUT_EN to also exercise the WAIT watchdog.
`timescale 1ns/1ps
module tb_regex_job_sequencer;
   import AXI_package::*;

   localparam int TB_TIMEOUT = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        jobValid;
   logic        jobReady;
   logic [15:0] codeWords;
   logic [15:0] stringLen;
   logic        inValid;
   logic        inReady;
   logic [39:0] inData;
   logic [39:0] addrReg;
   logic [39:0] dataInReg;
   logic [39:0] startCc;
   logic [39:0] endCc;
   logic [39:0] cmd;
   logic [39:0] status;
   logic [39:0] dataO;
   logic        resValid;
   logic        resReady;
   logic        resAccept;
   logic        resError;
   logic [39:0] resCycles;

   always #5 clk = ~clk;

   regex_job_sequencer #(
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .i_clk                       (clk),
      .i_rst                       (rst),
      .i_job_valid                 (jobValid),
      .o_job_ready                 (jobReady),
      .i_job_code_words            (codeWords),
      .i_job_string_len            (stringLen),
      .i_in_valid                  (inValid),
      .o_in_ready                  (inReady),
      .i_in_data                   (inData),
      .o_address_register          (addrReg),
      .o_data_in_register          (dataInReg),
      .o_start_cc_pointer_register (startCc),
      .o_end_cc_pointer_register   (endCc),
      .o_cmd_register              (cmd),
      .i_status_register           (status),
      .i_data_o_register           (dataO),
      .o_res_valid                 (resValid),
      .i_res_ready                 (resReady),
      .o_res_accept                (resAccept),
      .o_res_error                 (resError),
      .o_res_cycles                (resCycles)
   );

   int compared = 0;
   int mismatched = 0;

   logic [39:0] words [0:63];
   int          expWords, expStarts, expRead;
   logic [39:0] expStart, expEnd, expCycles;
   bit          expAccept, expError, expCheckCycles, expTimeout;
   int          consumed;

   int          axiRun;
   logic [39:0] axiFinal;

   int          writeIdx, startCount, readCount, resetCount, resHsCount, waitCount;
   logic [39:0] lastAddr, lastStart, lastEnd, lastResCycles;
   bit          lastResAccept, lastResError;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // AXI_top stand-in: RUNNING for axiRun cycles after the first START, then axiFinal.
   initial begin : axiModel
      int  axiCnt;
      bit  axiStarted;
      status     = STATUS_IDLE;
      axiStarted = 0;
      axiCnt     = 0;
      forever begin
         @(negedge clk);
         if (rst || cmd == CMD_RESET) begin
            status     = STATUS_IDLE;
            axiStarted = 0;
         end else if (cmd == CMD_START && !axiStarted) begin
            axiStarted = 1;
            axiCnt     = axiRun;
            status     = (axiRun == 0) ? axiFinal : STATUS_RUNNING;
         end else if (axiStarted && axiCnt > 0) begin
            axiCnt--;
            if (axiCnt == 0) status = axiFinal;
         end
      end
   end

   // Scoreboard: every command and every result cycle is compared to the job's expectations.
   initial begin : compareProc
      writeIdx = 0; startCount = 0; readCount = 0; resetCount = 0; resHsCount = 0; waitCount = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (jobValid && jobReady) begin
               writeIdx = 0; startCount = 0; readCount = 0;
               resetCount = 0; resHsCount = 0; waitCount = 0;
            end
            if (cmd == CMD_WRITE) begin
               checkOutput("write_after_consume", 64'(writeIdx < consumed), 64'd1);
               checkOutput("write_addr", 64'(addrReg), 64'(writeIdx));
               checkOutput("write_data", 64'(dataInReg), 64'(words[writeIdx % 64]));
               lastAddr = addrReg;
               writeIdx++;
            end else if (cmd == CMD_START) begin
               startCount++;
               checkOutput("start_cc", 64'(startCc), 64'(expStart));
               checkOutput("end_cc", 64'(endCc), 64'(expEnd));
               lastStart = startCc;
               lastEnd   = endCc;
            end else if (cmd == CMD_READ_ELAPSED_CLOCK) begin
               readCount++;
            end else if (cmd == CMD_RESET) begin
               checkOutput("reset_after_result", 64'(resHsCount), 64'd1);
               resetCount++;
            end else begin
               checkOutput("cmd_legal", 64'(cmd), 64'(CMD_NOP));
            end
`ifdef JOB_SEQ_TIMEOUT_EN
            if (startCount == 2 && cmd != CMD_START && resHsCount == 0 && !resValid) waitCount++;
`endif
            if (resValid) begin
               checkOutput("res_accept", 64'(resAccept), 64'(expAccept));
               checkOutput("res_error", 64'(resError), 64'(expError));
               if (expCheckCycles) checkOutput("res_cycles", 64'(resCycles), 64'(expCycles));
               if (resReady) begin
                  resHsCount++;
                  lastResCycles = resCycles;
                  lastResAccept = resAccept;
                  lastResError  = resError;
`ifdef JOB_SEQ_TIMEOUT_EN
                  if (expTimeout) checkOutput("timeout_wait_len", 64'(waitCount), 64'(TB_TIMEOUT + 1));
`endif
               end
            end
         end
      end
   end

   // Runs one job end to end; rstAfterStart>0 injects a reset that many cycles after START.
   task automatic applyStimulus(input int code, input int len, input int nOffered, input int gap,
                                input int runCycles, input logic [39:0] finalStatus,
                                input logic [39:0] dataVal, input int readyDelay,
                                input int rstAfterStart);
      int idx, gapLeft, cyc, resWait, sinceStart;
      bit hs, done, didReset;
      for (int i = 0; i < nOffered; i++) words[i] = {8'($urandom), 32'($urandom)};
      expWords   = (len == 0) ? 0 : code + (len + 4) / 5;
      expStarts  = (len == 0) ? 0 : 2;
      expStart   = 40'(code * 4 + 16);
      expEnd     = 40'(code * 4 + len - 1 + 16);
      expAccept  = 0; expError = 1; expRead = 0; expCycles = 40'd0;
      expCheckCycles = 0; expTimeout = 0;
      if (len != 0 && runCycles >= 3) begin
         if (finalStatus == STATUS_ACCEPTED || finalStatus == STATUS_REJECTED) begin
            expAccept = (finalStatus == STATUS_ACCEPTED);
            expError = 0; expRead = 1; expCycles = dataVal; expCheckCycles = 1;
         end else if (finalStatus == STATUS_RUNNING) begin
            expTimeout = 1; expCycles = 40'(TB_TIMEOUT); expCheckCycles = 1;
         end
      end
      axiRun = runCycles; axiFinal = finalStatus; dataO = dataVal; consumed = 0;

      codeWords = 16'(code); stringLen = 16'(len); jobValid = 1;
      hs = 0; cyc = 0;
      while (!hs && cyc < 20) begin
         @(negedge clk); hs = jobReady;
         @(posedge clk); #1; cyc++;
      end
      jobValid = 0;
      if (!hs) checkOutput("job_accept", 64'd0, 64'd1);

      idx = 0; gapLeft = gap; cyc = 0; resWait = 0; sinceStart = 0;
      done = 0; didReset = 0;
      while (!done && cyc < 3000) begin
         if (rstAfterStart > 0 && startCount > 0) begin
            sinceStart++;
            if (sinceStart >= rstAfterStart) begin
               checkOutput("pre_reset_running", 64'(status), 64'(STATUS_RUNNING));
               rst = 1; inValid = 0; resReady = 0;
               @(negedge clk);
               checkOutput("rst_cmd_nop", 64'(cmd), 64'(CMD_NOP));
               checkOutput("rst_res_valid", 64'(resValid), 64'd0);
               checkOutput("rst_job_ready", 64'(jobReady), 64'd0);
               @(posedge clk); #1; rst = 0;
               @(negedge clk);
               checkOutput("post_rst_idle", 64'(jobReady), 64'd1);
               checkOutput("post_rst_cmd", 64'(cmd), 64'(CMD_NOP));
               checkOutput("post_rst_start_cc", 64'(startCc), 64'd0);
               checkOutput("post_rst_addr", 64'(addrReg), 64'd0);
               checkOutput("post_rst_no_clear", 64'(resetCount), 64'd0);
               @(posedge clk); #1;
               done = 1; didReset = 1;
               break;
            end
         end
         if (!inValid && idx < nOffered) begin
            if (gapLeft > 0) gapLeft--;
            else begin inValid = 1; inData = words[idx]; end
         end
         resReady = (resWait >= readyDelay);
         @(negedge clk);
         hs = inValid && inReady;
         if (hs) consumed++;
         if (resValid) begin
            if (resReady) done = 1;
            else resWait++;
         end
         @(posedge clk); #1;
         if (hs) begin inValid = 0; idx++; gapLeft = gap; end
         cyc++;
      end
      inValid = 0; resReady = 0;
      if (!done) checkOutput("job_timeout", 64'd0, 64'd1);
      if (!didReset && done) begin
         hs = 0; cyc = 0;
         while (!hs && cyc < 10) begin
            @(negedge clk); hs = jobReady;
            @(posedge clk); #1; cyc++;
         end
         checkOutput("return_idle", 64'(hs), 64'd1);
         checkOutput("words_written", 64'(writeIdx), 64'(expWords));
         checkOutput("words_consumed", 64'(consumed), 64'(expWords));
         checkOutput("start_cycles", 64'(startCount), 64'(expStarts));
         checkOutput("read_cc_count", 64'(readCount), 64'(expRead));
         checkOutput("clear_count", 64'(resetCount), 64'd1);
         checkOutput("result_count", 64'(resHsCount), 64'd1);
      end
   endtask

   initial begin
      int code, len, run, pick;
      logic [39:0] fin;
      rst = 1; jobValid = 0; codeWords = 0; stringLen = 0;
      inValid = 0; inData = 0; resReady = 0; dataO = 0;
      axiRun = 0; axiFinal = STATUS_IDLE;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_job_ready", 64'(jobReady), 64'd0);
      checkOutput("reset_cmd", 64'(cmd), 64'(CMD_NOP));
      checkOutput("reset_res_valid", 64'(resValid), 64'd0);
      checkOutput("reset_addr", 64'(addrReg), 64'd0);
      checkOutput("reset_res_cycles", 64'(resCycles), 64'd0);
      @(posedge clk); #1; rst = 0;
      @(negedge clk);
      checkOutput("idle_job_ready", 64'(jobReady), 64'd1);
      checkOutput("idle_in_ready", 64'(inReady), 64'd0);
      @(posedge clk); #1;

      applyStimulus(3, 7, 7, 0, 50, STATUS_ACCEPTED, 40'd123, 2, 0);
      checkOutput("lit_consumed", 64'(consumed), 64'd5);
      checkOutput("lit_last_addr", 64'(lastAddr), 64'd4);
      checkOutput("lit_start_cc", 64'(lastStart), 64'h1C);
      checkOutput("lit_end_cc", 64'(lastEnd), 64'h22);
      checkOutput("lit_res_cycles", 64'(lastResCycles), 64'd123);
      checkOutput("lit_res_accept", 64'(lastResAccept), 64'd1);
      checkOutput("lit_clear_once", 64'(resetCount), 64'd1);

      applyStimulus(2, 4, 4, 1, 0, STATUS_IDLE, 40'd55, 0, 0);
      checkOutput("lit_idle_error", 64'(lastResError), 64'd1);
      checkOutput("lit_idle_no_read", 64'(readCount), 64'd0);

      applyStimulus(4, 12, 7, 4, 10, STATUS_REJECTED, 40'd77, 1, 0);
      checkOutput("lit_gap_writes", 64'(writeIdx), 64'd7);
      checkOutput("lit_rejected", 64'(lastResAccept), 64'd0);

      applyStimulus(1, 0, 2, 0, 5, STATUS_ACCEPTED, 40'd9, 0, 0);
      checkOutput("lit_len0_error", 64'(lastResError), 64'd1);
      checkOutput("lit_len0_writes", 64'(writeIdx), 64'd0);

      applyStimulus(2, 9, 5, 0, 500, STATUS_ACCEPTED, 40'd1, 0, 20);
      applyStimulus(0, 5, 2, 0, 4, STATUS_ACCEPTED, 40'hFF_FFFF_FFFF, 0, 0);

`ifdef JOB_SEQ_TIMEOUT_EN
      applyStimulus(1, 3, 2, 0, 5, STATUS_RUNNING, 40'd44, 0, 0);
      checkOutput("lit_timeout_cycles", 64'(lastResCycles), 64'(TB_TIMEOUT));
      checkOutput("lit_timeout_error", 64'(lastResError), 64'd1);
`endif

      for (int j = 0; j < 25; j++) begin
         code = $urandom_range(0, 6);
         len  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 23);
         run  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 40);
         pick = $urandom_range(0, 5);
         fin  = (pick < 2) ? STATUS_ACCEPTED : (pick < 4) ? STATUS_REJECTED :
                (pick == 4) ? STATUS_IDLE : 40'd7;
         applyStimulus(code, len, code + (len + 4) / 5 + $urandom_range(0, 2),
                       $urandom_range(0, 3), run, fin, {8'($urandom), 32'($urandom)},
                       $urandom_range(0, 3), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
